// File: rtl/edge_detect_stream.sv
// Streaming 3x3 Sobel edge detector: raster fetch addressing, two line buffers,
// a 3x3 window and a two-stage gradient/mode pipeline with fixed latency.
module edge_detect_stream #(
  parameter int PIXEL_W = 8,
  parameter int COL_NUM = 640,
  parameter int ROW_NUM = 480,
  parameter int COORD_W = 11,
  parameter int OUT_W   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               waitrequest,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic [1:0]         mode,
  input  logic [OUT_W-1:0]   threshold,
  output logic [COORD_W-1:0] next_pixel_x,
  output logic [COORD_W-1:0] next_pixel_y,
  output logic               readValid,
  output logic               sync,
  output logic [COORD_W-1:0] pixel_out_x,
  output logic [COORD_W-1:0] pixel_out_y,
  output logic [OUT_W-1:0]   pixel_out
);

  localparam int MAG_W  = PIXEL_W + 3;
  localparam int WIDE_W = (MAG_W > OUT_W) ? MAG_W : OUT_W;
  localparam int IDX_W  = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COL_NUM - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(ROW_NUM - 1);

  // Handshake: a pixel is taken on any cycle with en=1 and waitrequest=0 (reset wins);
  // the result side has no backpressure, readValid is a one-cycle strobe.
  logic accept;
  assign accept = en && !waitrequest && rst;

  logic [PIXEL_W-1:0] line1 [COL_NUM];
  logic [PIXEL_W-1:0] line2 [COL_NUM];
  logic [PIXEL_W-1:0] win   [3][3];
  logic [IDX_W-1:0]   col;
  logic [PIXEL_W-1:0] up1;
  logic [PIXEL_W-1:0] up2;

  assign col = next_pixel_x[IDX_W-1:0];
  assign up1 = line1[col];
  assign up2 = line2[col];

  logic [1:0]         active_mode;
  logic               v0_valid;
  logic               v0_sync;
  logic [1:0]         v0_mode;
  logic [COORD_W-1:0] v0_x;
  logic [COORD_W-1:0] v0_y;

  logic                      s1_valid;
  logic                      s1_sync;
  logic [1:0]                s1_mode;
  logic [COORD_W-1:0]        s1_x;
  logic [COORD_W-1:0]        s1_y;
  logic signed [MAG_W-1:0]   s1_gx;
  logic signed [MAG_W-1:0]   s1_gy;
  logic [PIXEL_W-1:0]        s1_center;

  logic signed [MAG_W-1:0] gx;
  logic signed [MAG_W-1:0] gy;
  logic [MAG_W-1:0]        abs_x;
  logic [MAG_W-1:0]        abs_y;
  logic [MAG_W-1:0]        mag;
  logic [WIDE_W-1:0]       mag_wide;
  logic [WIDE_W-1:0]       center_wide;
  logic [OUT_W-1:0]        sat;
  logic [OUT_W-1:0]        result;

  function automatic logic signed [MAG_W-1:0] ext(input logic [PIXEL_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  // Line memories and window hold data only; they never need clearing.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1[col] <= pixel;
      line2[col] <= up1;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 2; c++) begin
          win[r][c] <= win[r][c+1];
        end
      end
      win[0][2] <= up2;
      win[1][2] <= up1;
      win[2][2] <= pixel;
    end
  end

  // Address counter, frame mode latch and pipeline valids.
  always_ff @(posedge clk) begin
    if (!rst) begin
      next_pixel_x <= '0;
      next_pixel_y <= '0;
      active_mode  <= 2'd0;
      v0_valid     <= 1'b0;
      s1_valid     <= 1'b0;
      readValid    <= 1'b0;
      sync         <= 1'b0;
      pixel_out_x  <= '0;
      pixel_out_y  <= '0;
      pixel_out    <= '0;
    end else begin
      v0_valid  <= accept && (next_pixel_x >= COORD_W'(2)) && (next_pixel_y >= COORD_W'(2));
      s1_valid  <= v0_valid;
      readValid <= s1_valid;
      sync      <= s1_valid && s1_sync;
      if (s1_valid) begin
        pixel_out_x <= s1_x;
        pixel_out_y <= s1_y;
        pixel_out   <= result;
      end
      if (accept) begin
        if (next_pixel_x == '0 && next_pixel_y == '0) begin
          active_mode <= mode;
        end
        if (next_pixel_x == X_LAST) begin
          next_pixel_x <= '0;
          next_pixel_y <= (next_pixel_y == Y_LAST) ? '0 : next_pixel_y + COORD_W'(1);
        end else begin
          next_pixel_x <= next_pixel_x + COORD_W'(1);
        end
      end
    end
  end

  // Mode travels with each result so a new frame's mode never leaks into the old tail.
  always_ff @(posedge clk) begin
    if (accept) begin
      v0_x    <= next_pixel_x - COORD_W'(1);
      v0_y    <= next_pixel_y - COORD_W'(1);
      v0_sync <= (next_pixel_x == COORD_W'(2)) && (next_pixel_y == COORD_W'(2));
      v0_mode <= active_mode;
    end
    s1_gx     <= gx;
    s1_gy     <= gy;
    s1_center <= win[1][1];
    s1_x      <= v0_x;
    s1_y      <= v0_y;
    s1_sync   <= v0_sync;
    s1_mode   <= v0_mode;
  end

  always_comb begin
    gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
    gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
       - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
  end

  always_comb begin
    abs_x       = s1_gx[MAG_W-1] ? MAG_W'(-s1_gx) : MAG_W'(s1_gx);
    abs_y       = s1_gy[MAG_W-1] ? MAG_W'(-s1_gy) : MAG_W'(s1_gy);
    mag         = abs_x + abs_y;
    mag_wide    = WIDE_W'(mag);
    center_wide = WIDE_W'(s1_center);
    sat         = (mag_wide > WIDE_W'({OUT_W{1'b1}})) ? '1 : mag_wide[OUT_W-1:0];
    case (s1_mode)
      2'd1:    result = (sat >= threshold) ? '1 : '0;
      2'd2:    result = center_wide[OUT_W-1:0];
      default: result = sat;
    endcase
  end

endmodule

// File: tb/tb_edge_detect_stream.sv
// Bench for edge_detect_stream on an 8x6 image: a reference Sobel model fills an
// expected queue at each accept and a negedge monitor drains it against the outputs.
module tb_edge_detect_stream;

  localparam int PIXEL_W = 8;
  localparam int COL_NUM = 8;
  localparam int ROW_NUM = 6;
  localparam int COORD_W = 11;
  localparam int OUT_W   = 11;
  localparam int EW      = 16 + 1 + 3 * 11;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               waitrequest = 1'b0;
  logic [PIXEL_W-1:0] pixel = '0;
  logic [1:0]         mode = 2'd0;
  logic [OUT_W-1:0]   threshold = '0;
  logic [COORD_W-1:0] next_pixel_x;
  logic [COORD_W-1:0] next_pixel_y;
  logic               readValid;
  logic               sync;
  logic [COORD_W-1:0] pixel_out_x;
  logic [COORD_W-1:0] pixel_out_y;
  logic [OUT_W-1:0]   pixel_out;

  edge_detect_stream #(
    .PIXEL_W(PIXEL_W), .COL_NUM(COL_NUM), .ROW_NUM(ROW_NUM),
    .COORD_W(COORD_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .waitrequest(waitrequest), .pixel(pixel),
    .mode(mode), .threshold(threshold),
    .next_pixel_x(next_pixel_x), .next_pixel_y(next_pixel_y),
    .readValid(readValid), .sync(sync),
    .pixel_out_x(pixel_out_x), .pixel_out_y(pixel_out_y), .pixel_out(pixel_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [PIXEL_W-1:0] img [ROW_NUM][COL_NUM];
  logic [EW-1:0]      exp_q[$];
  logic [EW-1:0]      mon_e;
  logic [32:0]        last_out = '0;
  logic [1:0]         fmode = 2'd0;
  logic               mon_on = 1'b0;
  int                 mx = 0;
  int                 my = 0;
  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_pass = 0;
  int                 vcnt = 0;
  int                 scnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
  endtask

  function automatic logic [EW-1:0] exp_result(input int x, input int y);
    int cx, cy, gx, gy, mag, o;
    int p [3][3];
    logic s;
    cx = x - 1;
    cy = y - 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(img[cy-1+r][cx-1+c]);
    gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
    gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 2047) mag = 2047;
    case (fmode)
      2'd1:    o = (mag >= int'(threshold)) ? 2047 : 0;
      2'd2:    o = p[1][1];
      default: o = mag;
    endcase
    s = (cx == 1) && (cy == 1);
    return {16'(cyc + 2), s, 11'(cx), 11'(cy), 11'(o)};
  endfunction

  task automatic model_accept();
    if (mx == 0 && my == 0) fmode = mode;
    if (mx >= 2 && my >= 2) exp_q.push_back(exp_result(mx, my));
    if (mx == COL_NUM - 1) begin
      mx = 0;
      my = (my == ROW_NUM - 1) ? 0 : my + 1;
    end else begin
      mx++;
    end
  endtask

  // driver tasks
  task automatic step(input logic en_v, input logic wr_v);
    en = en_v;
    waitrequest = wr_v;
    pixel = img[my][mx];
    check("next_xy", {next_pixel_x, next_pixel_y}, {11'(mx), 11'(my)});
    tick();
    if (en_v && !wr_v) model_accept();
    #1;
  endtask

  task automatic run_accepts(input int n, input int stall);
    int acc;
    logic e, w;
    acc = 0;
    while (acc < n) begin
      e = (int'($urandom_range(0, 99)) >= stall);
      w = (int'($urandom_range(0, 99)) < stall / 2);
      step(e, w);
      if (e && !w) acc++;
    end
  endtask

  task automatic drain(input int exp_pulses, input int exp_syncs);
    repeat (4) step(1'b0, 1'b0);
    check("pulses", 64'(vcnt), 64'(exp_pulses));
    check("syncs", 64'(scnt), 64'(exp_syncs));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    vcnt = 0;
    scnt = 0;
  endtask

  // Reset is applied with a live accept request to show it takes priority.
  task automatic do_reset();
    rst = 1'b0;
    en = 1'b1;
    waitrequest = 1'b0;
    tick();
    exp_q.delete();
    last_out = '0;
    mx = 0;
    my = 0;
    fmode = 2'd0;
    vcnt = 0;
    scnt = 0;
    #1;
    check("reset_outputs", {readValid, sync, pixel_out_x, pixel_out_y, pixel_out,
                            next_pixel_x, next_pixel_y}, 64'd0);
    rst = 1'b1;
    en = 1'b0;
  endtask

  task automatic fill_img(input int kind);
    for (int y = 0; y < ROW_NUM; y++)
      for (int x = 0; x < COL_NUM; x++)
        case (kind)
          0:       img[y][x] = 8'd100;
          1:       img[y][x] = (x >= 4) ? 8'd255 : 8'd0;
          default: img[y][x] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
      if (readValid) begin
        vcnt++;
        if (sync) scnt++;
        if (exp_q.size() == 0) begin
          check("spurious_valid", {63'd0, readValid}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", {16'(cyc), sync, pixel_out_x, pixel_out_y, pixel_out}, 64'(mon_e));
          last_out = mon_e[32:0];
        end
      end else begin
        check("idle_hold", {sync, pixel_out_x, pixel_out_y, pixel_out}, {1'b0, last_out});
      end
    end
  end

  initial begin
    fill_img(0);
    do_reset();
    mon_on = 1'b1;

    mode = 2'd0;
    run_accepts(48, 0);
    drain(24, 1);

    fill_img(1);
    run_accepts(48, 0);
    drain(24, 1);

    mode = 2'd1;
    threshold = 11'd512;
    run_accepts(20, 0);
    mode = 2'd2;
    run_accepts(28, 0);
    drain(24, 1);
    run_accepts(48, 0);
    drain(24, 1);

    mode = 2'd0;
    fill_img(2);
    run_accepts(48, 40);
    drain(24, 1);

    fill_img(2);
    run_accepts(20, 40);
    do_reset();
    run_accepts(48, 0);
    drain(24, 1);

    fill_img(2);
    run_accepts(96, 0);
    drain(48, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/edge_detect_stream.md
Name: edge_detect_stream

Overview:
- Parametrised streaming 3x3 Sobel edge-detection engine; successor to the fixed 640x480, 8-bit edge-detection top.
- Generates raster-order fetch addresses, accepts one pixel per handshake, and buffers two image lines internally.
- Emits one result per interior pixel in one of three modes: gradient magnitude, binary threshold, or bypass.
- Sits between the frame-buffer read port and the display/compositor write path.

Parameters:
PIXEL_W, 8, input pixel width
COL_NUM, 640, image width (>=3)
ROW_NUM, 480, image height (>=3)
COORD_W, 11, coordinate width (must hold COL_NUM-1 and ROW_NUM-1)
OUT_W, 11, output sample width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
en  in  1  fetch enable
waitrequest  in  1  memory stall; no accept while high
pixel  in  PIXEL_W  data for current next_pixel_x/y, valid on accept
mode  in  2  0=magnitude, 1=threshold, 2=bypass, 3=reserved (treated as 0)
threshold  in  OUT_W  threshold for mode 1
next_pixel_x  out  COORD_W  fetch column
next_pixel_y  out  COORD_W  fetch row
readValid  out  1  one-cycle pulse: pixel_out and coordinates valid
sync  out  1  pulses with readValid for the first result of a frame, center (1,1)
pixel_out_x  out  COORD_W  result column
pixel_out_y  out  COORD_W  result row
pixel_out  out  OUT_W  result sample

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0; fetch address (0,0); pipeline valids cleared; active mode = 0. Line-buffer contents are not cleared; rows 0-1 are always refilled before any output.
- Accept: a cycle with en=1 and waitrequest=0. On accept, pixel belongs to (next_pixel_x, next_pixel_y).
- Address advance (next cycle after accept): x+1; at x=COL_NUM-1, x wraps to 0 and y+1; at (COL_NUM-1, ROW_NUM-1), wraps to (0,0). Address holds on any non-accept cycle.
- Line buffers: two COL_NUM-deep memories hold rows y-1 and y-2. Window: 3x3 shift registers advance only on accept.
- Result issue: an accept at (x,y) with x>=2 and y>=2 produces the result for center (x-1, y-1). Border rows and columns produce no output. A frame yields (COL_NUM-2)*(ROW_NUM-2) readValid pulses.
- Pipeline:
  - Stage 1: Gx and Gy in signed PIXEL_W+3 bits.
  - Stage 2: |Gx|+|Gy| in PIXEL_W+3 bits, mode select, output register.
  - Latency is fixed: readValid rises exactly 2 cycles after the triggering accept, regardless of later stalls. The pipeline free-runs with valid bits; there is no output backpressure.
- Arithmetic:
  - Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02), where prc = row r, col c of the window.
  - Magnitude saturates to 2^OUT_W-1 if OUT_W < PIXEL_W+3, and zero-extends otherwise.
- Modes:
  - 0: pixel_out = saturated magnitude.
  - 1: pixel_out = all-ones if magnitude >= threshold, else 0.
  - 2: pixel_out = center pixel, zero-extended (or MSB-truncated) to OUT_W.
- Mode latching: mode is sampled only on the accept at (0,0) and held for the whole frame. threshold is sampled live at stage 2.
- Non-readValid cycles: pixel_out and coordinates hold their last value; sync=0.
- Reset mid-frame: takes priority over accept in the same cycle; in-flight results are discarded (readValid=0 next cycle).

Test Plan:
All scenarios use COL_NUM=8, ROW_NUM=6, PIXEL_W=8, OUT_W=11.
1. Constant frame of 100, mode 0, en=1, waitrequest=0 -> 24 readValid pulses, all pixel_out=0. First pulse has sync=1 and center (1,1), 2 cycles after accepting (2,2).
2. Vertical step (cols 0-3 = 0, cols 4-7 = 255), mode 0 -> pixel_out=1020 at x=3 and x=4 for rows 1-4; 0 elsewhere.
3. Same image, mode 1, threshold=512 -> 2047 at x=3,4, else 0. Change mode to 2 mid-frame -> no effect until the next (0,0) accept; next frame outputs center pixels (0 or 255).
4. Random en/waitrequest stalls (~40%) over a random image -> result sequence and coordinates identical to the unstalled run. next_pixel holds during every stall; every readValid arrives exactly 2 cycles after its accept.
5. rst=0 after 20 accepts -> all outputs 0 and next_pixel=(0,0) the following cycle; no stale readValid; the following full frame matches golden.
6. Accept at (7,5) -> next_pixel=(0,0). Back-to-back frames produce identical results, and sync pulses once per frame.
